migration_dispatch: RTL and testbench

- Consumes per-particle results of the fixed-point position update stage: the new in-cell offset per axis plus the 2-bit cell_offset per axis.
- Particles whose three cell_offsets are all "stay" are written back to the local position cache.
- All other particles get a destination cell ID with periodic wrap-around, are buffered in a migration FIFO, and are sent to the migration router.
- Tracks per-iteration counts and signals completion once the last particle has been routed and the FIFO has drained.

---
 rtl/migration_dispatch_pkg.sv | 47 ++++
 rtl/migration_dispatch_mig_fifo.sv | 62 ++++++
 rtl/migration_dispatch.sv | 160 ++++++++++++++++
 tb/tb_migration_dispatch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/migration_dispatch_pkg.sv
// Shared widths, cell geometry, offset codes and the coordinate-step helper
// used by the migration dispatch block.
package migration_dispatch_pkg;

  localparam int OFFSET_WIDTH  = 27;
  localparam int CELL_ID_WIDTH = 3;
  localparam int PID_WIDTH     = 8;
  localparam int X_DIM         = 3;
  localparam int Y_DIM         = 3;
  localparam int Z_DIM         = 3;
  localparam int MIG_DEPTH     = 16;

  localparam logic [1:0] CO_STAY  = 2'b00;
  localparam logic [1:0] CO_PLUS  = 2'b01;
  localparam logic [1:0] CO_MINUS = 2'b11;

  typedef struct packed {
    logic [CELL_ID_WIDTH-1:0] z;
    logic [CELL_ID_WIDTH-1:0] y;
    logic [CELL_ID_WIDTH-1:0] x;
  } cell_coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  // Move one cell along an axis with periodic wrap; any non plus/minus
  // code (stay, or an illegal code already mapped to stay) keeps the coord.
  function automatic logic [CELL_ID_WIDTH-1:0] step_coord(
    input logic [CELL_ID_WIDTH-1:0] coord,
    input logic [1:0]               code,
    input int                       dim
  );
    logic [CELL_ID_WIDTH-1:0] top_coord;
    top_coord  = CELL_ID_WIDTH'(dim - 1);
    step_coord = coord;
    if (code == CO_PLUS) begin
      step_coord = (coord == top_coord) ? '0 : coord + 1'b1;
    end else if (code == CO_MINUS) begin
      step_coord = (coord == '0) ? top_coord : coord - 1'b1;
    end
  endfunction

endpackage

// File: rtl/migration_dispatch_mig_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on pop_data whenever empty is low.
module mig_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [WIDTH-1:0] push_data,
  input  logic          pop,
  output logic [WIDTH-1:0] pop_data,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Guard against pushing into a full FIFO and popping an empty one.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q < (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + (do_push ? 1'b1 : 1'b0);
    rd_ptr_d = rd_ptr_q + (do_pop ? 1'b1 : 1'b0);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers; reset drops all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/migration_dispatch.sv
// Splits position-update results into local writebacks (particle stays in
// this cell) and migration packets (destination cell with periodic wrap),
// buffers migrations in a FWFT FIFO, and reports per-iteration completion.
module migration_dispatch
  import migration_dispatch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PID_WIDTH-1:0]          in_pid,
  input  logic [3*OFFSET_WIDTH-1:0]     in_pos,
  input  logic [5:0]                    in_cell_offset,
  input  logic                          in_last,
  input  logic [3*CELL_ID_WIDTH-1:0]    home_cell,
  output logic                          wb_valid,
  output logic [PID_WIDTH-1:0]          wb_pid,
  output logic [3*OFFSET_WIDTH-1:0]     wb_pos,
  output logic                          mig_valid,
  input  logic                          mig_ready,
  output logic [3*CELL_ID_WIDTH-1:0]    mig_dst_cell,
  output logic [3*OFFSET_WIDTH-1:0]     mig_pos,
  output logic                          done,
  output logic [PID_WIDTH:0]            local_cnt,
  output logic [PID_WIDTH:0]            mig_cnt,
  output logic                          err_illegal
);

  localparam int POS_W   = 3*OFFSET_WIDTH;
  localparam int CELL_W  = 3*CELL_ID_WIDTH;
  localparam int FIFO_W  = CELL_W + POS_W;
  localparam int FIFO_AW = $clog2(MIG_DEPTH);

  md_state_t                state_q, state_d;
  logic [PID_WIDTH:0]       local_cnt_q, local_cnt_d;
  logic [PID_WIDTH:0]       mig_cnt_q, mig_cnt_d;
  logic                     err_q, err_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [PID_WIDTH-1:0]     wb_pid_q, wb_pid_d;
  logic [POS_W-1:0]         wb_pos_q, wb_pos_d;

  logic [1:0]               code [3];
  logic [1:0]               eff_code [3];
  logic [2:0]               axis_illegal;
  logic                     is_stay, accept, fifo_push, fifo_pop, fifo_empty;
  cell_coord_t              home, dst;
  logic [FIFO_W-1:0]        fifo_out;
  logic [FIFO_AW:0]         fifo_count;

  assign home = cell_coord_t'(home_cell);

  // Per-axis decode: an illegal 10 code is flagged and then treated as stay.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
      assign code[gi]         = in_cell_offset[2*gi +: 2];
      assign axis_illegal[gi] = (code[gi] == 2'b10);
      assign eff_code[gi]     = axis_illegal[gi] ? CO_STAY : code[gi];
    end
  endgenerate

  // Destination cell and the stay/migrate decision for the offered beat.
  always_comb begin
    dst.x   = step_coord(home.x, eff_code[0], X_DIM);
    dst.y   = step_coord(home.y, eff_code[1], Y_DIM);
    dst.z   = step_coord(home.z, eff_code[2], Z_DIM);
    is_stay = (eff_code[0] == CO_STAY) && (eff_code[1] == CO_STAY) &&
              (eff_code[2] == CO_STAY);
  end

  // One slot is held back so a full-rate stream never overruns the FIFO.
  assign in_ready  = ((state_q == ST_IDLE) || (state_q == ST_RUN)) &&
                     (fifo_count < (FIFO_AW+1)'(MIG_DEPTH - 1));
  assign accept    = in_valid && in_ready;
  assign fifo_push = accept && !is_stay;
  assign fifo_pop  = mig_valid && mig_ready;

  mig_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MIG_DEPTH)
  ) u_mig_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({dst, in_pos}),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Iteration FSM, saturating counters, sticky error and writeback staging.
  always_comb begin
    state_d     = state_q;
    local_cnt_d = local_cnt_q;
    mig_cnt_d   = mig_cnt_q;
    err_d       = err_q;
    wb_valid_d  = 1'b0;
    wb_pid_d    = wb_pid_q;
    wb_pos_d    = wb_pos_q;

    case (state_q)
      ST_IDLE:  if (accept) state_d = in_last ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_count == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept) begin
      // The first beat of an iteration starts counting from zero.
      if (state_q == ST_IDLE) begin
        local_cnt_d = '0;
        mig_cnt_d   = '0;
      end
      if (is_stay) begin
        if (local_cnt_d != '1) local_cnt_d = local_cnt_d + 1'b1;
        wb_valid_d = 1'b1;
        wb_pid_d   = in_pid;
        wb_pos_d   = in_pos;
      end else if (mig_cnt_d != '1) begin
        mig_cnt_d = mig_cnt_d + 1'b1;
      end
      if (|axis_illegal) err_d = 1'b1;
    end
  end

  // State and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      local_cnt_q <= '0;
      mig_cnt_q   <= '0;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_pid_q    <= '0;
      wb_pos_q    <= '0;
    end else begin
      state_q     <= state_d;
      local_cnt_q <= local_cnt_d;
      mig_cnt_q   <= mig_cnt_d;
      err_q       <= err_d;
      wb_valid_q  <= wb_valid_d;
      wb_pid_q    <= wb_pid_d;
      wb_pos_q    <= wb_pos_d;
    end
  end

  assign mig_valid    = !fifo_empty;
  // Packet fields read as zero while no packet is presented.
  assign mig_dst_cell = fifo_empty ? '0 : fifo_out[FIFO_W-1:POS_W];
  assign mig_pos      = fifo_empty ? '0 : fifo_out[POS_W-1:0];
  assign done         = (state_q == ST_DONE);
  assign local_cnt    = local_cnt_q;
  assign mig_cnt      = mig_cnt_q;
  assign err_illegal  = err_q;
  assign wb_valid     = wb_valid_q;
  assign wb_pid       = wb_pid_q;
  assign wb_pos       = wb_pos_q;

endmodule

// File: tb/tb_migration_dispatch.sv
// Self-checking bench for migration_dispatch: directed scenarios plus
// randomized iterations, all compared against a queue-based reference model.
module tb_migration_dispatch;
  import migration_dispatch_pkg::*;

  localparam int PW = 3*OFFSET_WIDTH;
  localparam int CW = 3*CELL_ID_WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_last;
  logic [PID_WIDTH-1:0] in_pid;
  logic [PW-1:0]     in_pos;
  logic [5:0]        in_cell_offset;
  logic [CW-1:0]     home_cell;
  logic              wb_valid;
  logic [PID_WIDTH-1:0] wb_pid;
  logic [PW-1:0]     wb_pos;
  logic              mig_valid, mig_ready;
  logic [CW-1:0]     mig_dst_cell;
  logic [PW-1:0]     mig_pos;
  logic              done;
  logic [PID_WIDTH:0] local_cnt, mig_cnt;
  logic              err_illegal;

  always #5 clk = ~clk;

  migration_dispatch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pid(in_pid), .in_pos(in_pos),
    .in_cell_offset(in_cell_offset), .in_last(in_last), .home_cell(home_cell),
    .wb_valid(wb_valid), .wb_pid(wb_pid), .wb_pos(wb_pos),
    .mig_valid(mig_valid), .mig_ready(mig_ready), .mig_dst_cell(mig_dst_cell),
    .mig_pos(mig_pos), .done(done), .local_cnt(local_cnt), .mig_cnt(mig_cnt),
    .err_illegal(err_illegal)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 waiting for an iteration, 1 collecting, 2 draining, 3 finishing
  logic [CW+PW-1:0] m_q[$];
  int               phase;
  int               m_local, m_mig;
  bit               m_err, m_wb_v;
  logic [PID_WIDTH-1:0] m_wb_pid;
  logic [PW-1:0]    m_wb_pos;
  int               hx, hy, hz;
  bit               last_acc, last_done;

  function automatic int delta_of(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int wrap(input int c, input int d, input int dim);
    return (c + d + dim) % dim;
  endfunction

  task automatic model_reset();
    m_q.delete();
    phase = 0; m_local = 0; m_mig = 0; m_err = 0; m_wb_v = 0;
  endtask

  task automatic set_home(input int z, input int y, input int x);
    hz = z; hy = y; hx = x;
    home_cell = {CELL_ID_WIDTH'(z), CELL_ID_WIDTH'(y), CELL_ID_WIDTH'(x)};
  endtask

  function automatic logic [PW-1:0] rand_pos();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  // One clock: compare DUT to model at negedge, then advance the model.
  task automatic cycle();
    bit exp_ready, acc, pop;
    int ph, sz, dx, dy, dz;
    logic [CW-1:0] dst;
    @(negedge clk);
    exp_ready = (phase < 2) && (m_q.size() < MIG_DEPTH - 1);
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("mig_valid", mig_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check_eq("mig_dst", mig_dst_cell, m_q[0][CW+PW-1:PW]);
      check_eq("mig_pos", mig_pos, m_q[0][PW-1:0]);
    end
    check_eq("wb_valid", wb_valid, m_wb_v);
    if (m_wb_v) begin
      check_eq("wb_pid", wb_pid, m_wb_pid);
      check_eq("wb_pos", wb_pos, m_wb_pos);
    end
    check_eq("done", done, phase == 3);
    check_eq("local_cnt", local_cnt, m_local);
    check_eq("mig_cnt", mig_cnt, m_mig);
    check_eq("err_illegal", err_illegal, m_err);
    last_done = done;
    acc = in_valid && exp_ready;
    pop = (m_q.size() != 0) && mig_ready;
    @(posedge clk);
    #1;
    last_acc = acc && !rst;
    if (rst) begin
      model_reset();
    end else begin
      ph = phase; sz = m_q.size();
      m_wb_v = 0;
      if (ph == 3) phase = 0;
      else if (ph == 2 && sz == 0) phase = 3;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        if (ph == 0) begin m_local = 0; m_mig = 0; phase = 1; end
        for (int a = 0; a < 3; a++)
          if (in_cell_offset[2*a +: 2] == 2'b10) m_err = 1;
        dx = delta_of(in_cell_offset[1:0]);
        dy = delta_of(in_cell_offset[3:2]);
        dz = delta_of(in_cell_offset[5:4]);
        if (dx == 0 && dy == 0 && dz == 0) begin
          m_wb_v = 1; m_wb_pid = in_pid; m_wb_pos = in_pos;
          if (m_local < 511) m_local++;
        end else begin
          dst = {CELL_ID_WIDTH'(wrap(hz, dz, Z_DIM)), CELL_ID_WIDTH'(wrap(hy, dy, Y_DIM)),
                 CELL_ID_WIDTH'(wrap(hx, dx, X_DIM))};
          m_q.push_back({dst, in_pos});
          if (m_mig < 511) m_mig++;
        end
        if (in_last) phase = 2;
      end
    end
  endtask

  task automatic offer(input int pid, input logic [PW-1:0] pos, input logic [5:0] co, input bit last);
    in_valid = 1; in_pid = PID_WIDTH'(pid); in_pos = pos; in_cell_offset = co; in_last = last;
    last_acc = 0;
    for (int i = 0; i < 200 && !last_acc; i++) cycle();
    check_eq("offer_accepted", last_acc, 1'b1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_idle(output int pulses);
    pulses = 0; in_valid = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (last_done) pulses++;
      if (phase == 0) break;
    end
    check_eq("reached_idle", phase, 0);
  endtask

  int pulses, extra, n_acc, k, n;
  logic [PW-1:0] p;

  initial begin
    rst = 1; in_valid = 0; in_pid = '0; in_pos = '0; in_cell_offset = '0; in_last = 0;
    mig_ready = 0; set_home(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle();                      // reset state checked by the model
    rst = 0;
    cycle();

    // 1: four stay particles
    mig_ready = 1;
    for (int i = 0; i < 4; i++) offer(i, rand_pos(), 6'b00_00_00, i == 3);
    wait_idle(pulses);
    check_eq("s1_done_pulses", pulses, 1);
    check_eq("s1_local_cnt", local_cnt, 4);
    check_eq("s1_mig_cnt", mig_cnt, 0);

    // 2: wrap-around destinations
    mig_ready = 0; set_home(0, 0, 0);
    offer(5, rand_pos(), 6'b00_00_11, 1);
    check_eq("dst_wrap_low", mig_dst_cell, {3'd0, 3'd0, 3'd2});
    mig_ready = 1; wait_idle(pulses);
    mig_ready = 0; set_home(2, 2, 2);
    offer(6, rand_pos(), 6'b00_00_01, 1);
    check_eq("dst_wrap_high", mig_dst_cell, {3'd2, 3'd2, 3'd0});
    mig_ready = 1; wait_idle(pulses);
    mig_ready = 0; set_home(1, 1, 1);
    p = rand_pos();
    offer(7, p, 6'b11_01_01, 1);
    check_eq("dst_diag", mig_dst_cell, {3'd0, 3'd2, 3'd2});
    check_eq("dst_diag_pos", mig_pos, p);
    mig_ready = 1; wait_idle(pulses);
    check_eq("s2_done_pulses", pulses, 1);

    // 3: stalled router, 20 migrating beats
    mig_ready = 0; set_home(1, 0, 2); n_acc = 0;
    for (int i = 0; i < 25; i++) begin
      in_valid = 1; in_pid = PID_WIDTH'(n_acc); in_pos = rand_pos();
      in_cell_offset = 6'b00_01_01; in_last = (n_acc == 19);
      cycle();
      if (last_acc) n_acc++;
    end
    check_eq("stall_accepts", n_acc, 15);
    mig_ready = 1;
    for (int i = 0; i < 100 && n_acc < 20; i++) begin
      in_valid = 1; in_pid = PID_WIDTH'(n_acc); in_pos = rand_pos();
      in_cell_offset = 6'b11_00_01; in_last = (n_acc == 19);
      cycle();
      if (last_acc) n_acc++;
    end
    check_eq("stall_total_accepts", n_acc, 20);
    wait_idle(pulses);
    check_eq("s3_done_pulses", pulses, 1);
    check_eq("s3_mig_cnt", mig_cnt, 20);

    // 4: migrating last beat with router stalled for 10 cycles
    mig_ready = 0; set_home(2, 1, 0);
    offer(9, rand_pos(), 6'b00_11_00, 1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin cycle(); if (last_done) extra++; end
    mig_ready = 1; wait_idle(pulses);
    check_eq("s4_done_pulses", pulses + extra, 1);

    // 5: illegal code on y, then reset during drain
    offer(10, rand_pos(), 6'b00_10_00, 1);
    wait_idle(pulses);
    check_eq("s5_local_cnt", local_cnt, 1);
    mig_ready = 0;
    offer(11, rand_pos(), 6'b00_00_01, 0);
    offer(12, rand_pos(), 6'b01_00_00, 1);
    repeat (3) cycle();
    check_eq("err_sticky", err_illegal, 1'b1);
    rst = 1; cycle(); rst = 0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (last_done) extra++; end
    check_eq("rst_no_done", extra, 0);
    check_eq("rst_mig_valid", mig_valid, 1'b0);

    // 6: randomized iterations
    for (int it = 0; it < 4; it++) begin
      set_home($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      n = 10 + $urandom_range(0, 20); k = 0;
      for (int c = 0; c < 1000 && k < n; c++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_pid = PID_WIDTH'($urandom()); in_pos = rand_pos();
        in_cell_offset = 6'($urandom()); in_last = (k == n - 1);
        mig_ready = ($urandom_range(0, 3) != 0);
        cycle();
        if (last_acc) k++;
      end
      check_eq("rand_all_accepted", k, n);
      mig_ready = 1; wait_idle(pulses);
      check_eq("rand_done_pulses", pulses, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
